// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 single-bit mux, with a
// per-grant quantum and a registered mux output. Optional RR_MUX_LOCK_EN adds a lock input.
module rr_mux_arbiter #(
  parameter int QUANTUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
`ifdef RR_MUX_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       y
);

  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_d;
  logic [1:0]       ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       s_d;
  logic [3:0]       gnt_d;
  logic             busy_d;
  logic             y_d;
  logic [2:0]       pick;
  logic             lock_act;

`ifdef RR_MUX_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Returns {found, index}; searches p, p+1, p+2, p+3 (mod 4), lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      s     <= 2'd0;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
      y     <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
      s     <= s_d;
      gnt   <= gnt_d;
      busy  <= busy_d;
      y     <= y_d;
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    s_d     = s;
    pick    = 3'b000;
    case (state)
      IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[2]) begin
          state_d = GRANT;
          s_d     = pick[1:0];
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (req[s] && (cnt < CNT_MAX)) begin
          cnt_d = cnt + CNT_ONE;
        end else if (req[s] && lock_act) begin
          cnt_d = CNT_MAX;
        end else begin
          // Release and re-arbitrate in the same cycle so there is no idle bubble.
          ptr_d = s + 2'd1;
          pick  = rr_pick(req, s + 2'd1);
          if (pick[2]) begin
            s_d   = pick[1:0];
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // y uses the pre-edge busy/s, so it trails the grant by one cycle.
  always_comb begin
    gnt_d  = (state_d == GRANT) ? (4'b0001 << s_d) : 4'b0000;
    busy_d = (state_d == GRANT);
    y_d    = busy ? i[s] : 1'b0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed per-cycle vectors push expected
// outputs; a monitor pops and compares one entry after every clock edge.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       busy;
  logic       y;
`ifdef RR_MUX_LOCK_EN
  logic       lock;
  logic       lock_nxt;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       busy;
    logic       y;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  rr_mux_arbiter #(.QUANTUM(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .i    (i),
`ifdef RR_MUX_LOCK_EN
    .lock (lock),
`endif
    .gnt  (gnt),
    .s    (s),
    .busy (busy),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] di,
                      input logic [3:0] eg, input logic [1:0] es, input logic eb,
                      input logic ey, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    i   = di;
`ifdef RR_MUX_LOCK_EN
    lock = lock_nxt;
`endif
    e.gnt  = eg;
    e.s    = es;
    e.busy = eb;
    e.y    = ey;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || s !== e.s || busy !== e.busy || y !== e.y) begin
          failures++;
          $display("FAIL %s: got gnt=%b s=%0d busy=%b y=%b, expected gnt=%b s=%0d busy=%b y=%b",
                   e.name, gnt, s, busy, y, e.gnt, e.s, e.busy, e.y);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] eg;
    logic [1:0] es;
    logic       ey;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    req = 4'b0000;
    i   = 4'b0000;
`ifdef RR_MUX_LOCK_EN
    lock     = 1'b0;
    lock_nxt = 1'b0;
`endif

    // Reset held with all requests and data high, then full round-robin rotation.
    step(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c0");
    step(1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_c1");
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        es = 2'(g % 4);
        eg = 4'b0001 << es;
        ey = (g == 0 && c == 0) ? 1'b0 : 1'b1;
        step(1'b0, 4'b1111, 4'b1111, eg, es, 1'b1, ey, $sformatf("rotate_g%0d_c%0d", g, c));
      end
    end

    // Sole requester re-granted across quantum boundaries with no gap.
    step(1'b1, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, "sole_reset");
    for (int c = 1; c <= 12; c++) begin
      ey = (c == 1) ? 1'b0 : 1'b1;
      step(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, ey, $sformatf("sole_c%0d", c));
    end

    // Early release hands over without a bubble; idle keeps s.
    step(1'b1, 4'b0000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "drop_reset");
    step(1'b0, 4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0, "drop_g1_a");
    step(1'b0, 4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0, "drop_g1_b");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "drop_to_g3");
    step(1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1, "idle_s_hold_a");
    step(1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0, "idle_s_hold_b");

    // Data path lag, reset mid-grant, pointer restart.
    step(1'b1, 4'b0000, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0, "data_reset");
    step(1'b0, 4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "data_g1_a");
    step(1'b0, 4'b0010, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, "data_g1_b");
    step(1'b0, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b1, "data_g0_a");
    step(1'b0, 4'b0001, 4'b1010, 4'b0001, 2'd0, 1'b1, 1'b0, "data_g0_b");
    step(1'b1, 4'b0001, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_mid_grant");
    step(1'b0, 4'b0110, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "ptr_restart_a");
    step(1'b0, 4'b0110, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b1, "ptr_restart_b");

`ifdef RR_MUX_LOCK_EN
    // Lock holds past the quantum; clearing it releases the saturated grant.
    lock_nxt = 1'b0;
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "lock_reset");
    lock_nxt = 1'b1;
    for (int c = 1; c <= 10; c++)
      step(1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("lock_hold_c%0d", c));
    lock_nxt = 1'b0;
    step(1'b0, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "lock_release");
    lock_nxt = 1'b1;
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "lock_drop_req");
`endif

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
